// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit: single-cycle 32x32 multiply and 32-step
// restoring divide, with results presented on the HI/LO write ports.
module mul_div_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        wen_hi,
    output logic [31:0] hi,
    output logic        wen_lo,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES - 1);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [63:0] rem_q, rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s;
    logic        ge_s;
    logic [31:0] diff_s;
    logic [63:0] step_rem_s;
    logic        signed_op_s;
    logic        neg_quot_s;
    logic        neg_rem_s;
    logic        div_zero_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;

    // Two's-complement magnitude; the most negative value maps onto 2^31 unchanged.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        logic [31:0] r;
        if (is_signed && v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] v, input logic do_neg);
        logic [31:0] r;
        if (do_neg) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Datapath: product, one restoring-division step and the final sign fix-up.
    always_comb begin
        signed_op_s = ~op_q[0];
        prod_s      = {{32{signed_op_s & src1_q[31]}}, src1_q} *
                      {{32{signed_op_s & src2_q[31]}}, src2_q};
        // Upper 33 bits of the shifted remainder compared against the divisor.
        ge_s        = (rem_q[63:31] >= {1'b0, dvsr_q});
        diff_s      = rem_q[62:31] - dvsr_q;
        if (ge_s) begin
            step_rem_s = {diff_s, rem_q[30:0], 1'b1};
        end else begin
            step_rem_s = {rem_q[62:0], 1'b0};
        end
        neg_quot_s  = signed_op_s & (src1_q[31] ^ src2_q[31]);
        neg_rem_s   = signed_op_s & src1_q[31];
        div_zero_s  = (src2_q == 32'd0);
        if (div_zero_s) begin
            quot_fix_s = 32'hFFFF_FFFF;
            rem_fix_s  = src1_q;
        end else begin
            quot_fix_s = neg32(rem_q[31:0], neg_quot_s);
            rem_fix_s  = neg32(rem_q[63:32], neg_rem_s);
        end
    end

    // Next-state logic: sequencing, operand capture and result writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dvsr_d  = dvsr_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    op_d   = op;
                    src1_d = src1;
                    src2_d = src2;
                    cnt_d  = 6'd0;
                    if (op[1]) begin
                        state_d = ST_DIV;
                        dvsr_d  = mag32(src2, ~op[0]);
                        rem_d   = {32'd0, mag32(src1, ~op[0])};
                    end else begin
                        state_d = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                hi_d    = prod_s[63:32];
                lo_d    = prod_s[31:0];
                state_d = ST_DONE;
            end
            ST_DIV: begin
                rem_d = step_rem_s;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX: begin
                lo_d    = quot_fix_s;
                hi_d    = rem_fix_s;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A flush overrides whatever the active state wanted to do next.
        if (cancel && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 2'd0;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            dvsr_q  <= 32'd0;
            rem_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            dvsr_q  <= dvsr_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Status and write-port outputs; done is gated combinationally by cancel.
    always_comb begin
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE) && !cancel;
        wen_hi = done;
        wen_lo = done;
        hi     = hi_q;
        lo     = lo_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases followed by
// randomized operations compared against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        wen_hi;
    logic [31:0] hi;
    logic        wen_lo;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_hi;
    logic [31:0] last_lo;
    bit          hold_known;

    mul_div_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .wen_hi (wen_hi),
        .hi     (hi),
        .wen_lo (wen_lo),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l);
        longint x, y, p, q, r;
        longint unsigned ux, uy, up;
        case (o)
            2'b00: begin
                x = $signed(a); y = $signed(b); p = x * y;
                h = p[63:32]; l = p[31:0];
            end
            2'b01: begin
                ux = a; uy = b; up = ux * uy;
                h = up[63:32]; l = up[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF;
                end else begin
                    x = $signed(a); y = $signed(b); q = x / y; r = x % y;
                    h = r[31:0]; l = q[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF;
                end else begin
                    h = a % b; l = a / b;
                end
            end
        endcase
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'd1;
            4: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue in an idle cycle, then follow every cycle up to and including done.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        lat = o[1] ? 34 : 2;
        @(negedge clk);
        start = 1'b1; cancel = 1'b0; op = o; src1 = a; src2 = b;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        if (hold_known) begin
            chk("hold_hi", hi, last_hi);
            chk("hold_lo", lo, last_lo);
        end else begin
            hold_known = 1'b0;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            start = hold;
            if (hold) begin
                op = 2'($urandom_range(0, 3)); src1 = $urandom; src2 = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            chk("busy", busy, 1'b1);
            chk("done", done, (k == lat));
            chk("wen_hi", wen_hi, (k == lat));
            chk("wen_lo", wen_lo, (k == lat));
            if (k == lat) begin
                chk("res_hi", hi, eh);
                chk("res_lo", lo, el);
            end
        end
        last_hi = eh; last_lo = el; hold_known = 1'b1;
    endtask

    // Start an operation and flush it in the k-th cycle after acceptance.
    task automatic run_cancel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                              input int kc);
        @(negedge clk);
        start = 1'b1; cancel = 1'b0; op = o; src1 = a; src2 = b;
        #1;
        chk("cidle_busy", busy, 1'b0);
        for (int j = 1; j <= kc; j++) begin
            @(negedge clk);
            start = 1'b0; cancel = (j == kc);
            #1;
            chk("cbusy", busy, 1'b1);
            chk("cdone", done, 1'b0);
            chk("cwen", wen_hi | wen_lo, 1'b0);
        end
        hold_known = 1'b0;
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, mh, ml;
        resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'd0; src1 = 32'd0; src2 = 32'd0;
        last_hi = 32'd0; last_lo = 32'd0; hold_known = 1'b1;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wen", wen_hi | wen_lo, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        run_cancel(2'b11, 32'd12345, 32'd17, 10);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_cancel(2'b00, 32'd5, 32'd6, 2);

        // Simultaneous start and cancel in IDLE must not launch anything.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 2'b11; src1 = 32'd9; src2 = 32'd3;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        #1;
        chk("cancel_wins", busy, 1'b0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 2'b10; src1 = 32'hDEAD_BEEF; src2 = 32'd3;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("pre_rst_busy", busy, 1'b1);
        end
        #1 resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_wen", wen_hi | wen_lo, 1'b0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        last_hi = 32'd0; last_lo = 32'd0; hold_known = 1'b1;
        run_op(2'b11, 32'd1000, 32'd33, 1'b1, 32'd10, 32'd30);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            model(ro, ra, rb, mh, ml);
            run_op(ro, ra, rb, ($urandom_range(0, 3) == 0), mh, ml);
        end

        @(negedge clk);
        start = 1'b0;
        #1;
        chk("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
